mdio_responder: RTL and testbench
=================================

MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 The block SHALL take parameter PHY_ADDR, default 5'd1, which is the PHY address this responder answers to.
REQ-002 The block SHALL take parameter PREAMBLE_MIN, default 32, which is the number of consecutive 1 bits required before a start frame is accepted.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; mdc is oversampled on it, and there is one clock only.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port mdc, input, 1 bit: management clock from the station, asynchronous to clk, at most clk/8.
REQ-006 The block SHALL have port mdio_i, input, 1 bit: MDIO line value, asynchronous.
REQ-007 The block SHALL have port mdio_o, output, 1 bit: MDIO drive value.
REQ-008 The block SHALL have port mdio_oe, output, 1 bit: MDIO output enable; 1 drives mdio_o, 0 leaves the line high-Z. The tristate buffer lives outside this block.
REQ-009 The block SHALL have port reg_addr, output, 5 bits: register address of the current frame.
REQ-010 The block SHALL have port reg_re, output, 1 bit: one-clk read strobe.
REQ-011 The block SHALL have port reg_rdata, input, 16 bits: read data, valid one clk after reg_re.
REQ-012 The block SHALL have port reg_we, output, 1 bit: one-clk write strobe.
REQ-013 The block SHALL have port reg_wdata, output, 16 bits: write data, valid while reg_we=1.
REQ-014 The block SHALL have port busy, output, 1 bit: high from ST acceptance until return to S_IDLE.
REQ-015 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on protocol violation.

Function
REQ-016 mdc and mdio_i SHALL each pass through a 2-FF synchronizer of identical depth; an MDC rise SHALL be the cycle where synced mdc=1 and the previous synced mdc=0; all bit sampling and all output updates SHALL occur only on MDC-rise cycles.
REQ-017 The state machine SHALL have states S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RD_DATA, S_WR_DATA and S_SKIP.
REQ-018 In S_IDLE, the preamble counter SHALL increment on each sampled 1 (saturating at PREAMBLE_MIN) and clear on each sampled 0; a 0 sampled with counter>=PREAMBLE_MIN SHALL go to S_ST.
REQ-019 In S_ST, a sampled 1 SHALL go to S_OP and set busy; a sampled 0 SHALL pulse frame_err and go to S_IDLE.
REQ-020 In S_OP, 2 bits SHALL be sampled; 10 = read, 01 = write; 00 or 11 SHALL pulse frame_err and go to S_IDLE.
REQ-021 S_PHYAD and S_REGAD SHALL each shift in 5 bits MSB-first; the reg_addr output SHALL update when the last REGAD bit is sampled.
REQ-022 If the received PHYAD differs from PHY_ADDR, the block SHALL go to S_SKIP for 18 MDC rises, then to S_IDLE, with mdio_oe=0, no strobes and no frame_err.
REQ-023 For an addressed read, reg_re SHALL pulse one clk on the MDC-rise cycle that samples the last REGAD bit; reg_rdata SHALL be captured into the shift register the following clk.
REQ-024 Read TA: mdio_oe SHALL stay 0 at the 1st TA rise; on the 2nd TA rise, mdio_oe=1 and mdio_o=0.
REQ-025 Read data: on each of the next 16 rises, mdio_o SHALL present bits 15 down to 0; on the 17th rise, mdio_oe=0, and the block SHALL go to S_IDLE.
REQ-026 Write TA: the two sampled bits SHALL be 1 then 0; any mismatch SHALL pulse frame_err and go to S_IDLE without writing.
REQ-027 Write data: 16 bits SHALL be sampled MSB-first; reg_wdata and a one-clk reg_we pulse SHALL follow within 1 clk of the 16th sample; then the block SHALL go to S_IDLE.
REQ-028 After every frame end or error, the preamble counter SHALL restart at 0, so that a fresh preamble is required.
REQ-029 mdio_oe SHALL never be 1 outside S_TA (2nd bit) and S_RD_DATA.
REQ-030 reg_re and reg_we SHALL never be high in the same clk.
REQ-031 No timeout SHALL exist; a stalled mdc SHALL freeze the state machine.

Reset
REQ-032 While rst=1, each of the following SHALL be 0: mdio_o, mdio_oe, reg_re, reg_we, busy, frame_err, reg_addr, reg_wdata, the synchronizers and the preamble counter, and the state SHALL be S_IDLE.
REQ-033 Reset asserted mid-frame, including during a read drive, SHALL take effect at the next clk edge; mdio_oe SHALL be 0 the cycle after rst is sampled.
REQ-034 After reset, the block SHALL require a full preamble before accepting a frame.

Verification
REQ-035 Read: 32 ones, then ST=01, OP=10, PHYAD=00001, REGAD=00010, with reg_rdata=16'hA5C3 -> one reg_re pulse with reg_addr=2; mdio_oe low at TA bit 1; 0 driven at TA bit 2; bits 1010010111000011 driven MSB-first; mdio_oe=0 after bit 0.
REQ-036 Write: preamble, then 01 01 00001 00100 10, data 16'h1234 -> one reg_we pulse with reg_addr=4 and reg_wdata=16'h1234; mdio_oe=0 throughout.
REQ-037 Other PHY: read frame with PHYAD=00011 -> no strobes, mdio_oe=0, busy drops after 18 skipped rises, and a following valid frame is accepted.
REQ-038 Errors: 31-one preamble -> frame ignored; OP=11 -> one frame_err pulse; write TA=11 -> one frame_err pulse, no reg_we.
REQ-039 Reset mid-read: rst asserted during data bit 7 -> mdio_oe=0 the next clk, busy=0, and the next full frame completes correctly.
REQ-040 Back-to-back: two write frames with mdc at clk/8 and minimum preamble -> exactly two reg_we pulses with the correct data.

Source files
------------

// File: rtl/mdio_responder.sv
// MDIO (clause 22) management responder: oversamples mdc on clk and serves
// read/write frames addressed to PHY_ADDR through a simple register strobe port.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        reg_we,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic        frame_err
);

  // state     | meaning
  // S_IDLE    | counting preamble ones, waiting for ST first bit (0)
  // S_ST      | expecting ST second bit (1)
  // S_OP      | two opcode bits
  // S_PHYAD   | five PHY address bits
  // S_REGAD   | five register address bits
  // S_TA      | turnaround: read releases then drives 0, write checks 10
  // S_RD_DATA | driving 16 data bits, then releasing the line
  // S_WR_DATA | sampling 16 data bits
  // S_SKIP    | frame for another PHY, ignoring TA + data
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ST      = 4'd1;
  localparam logic [3:0] S_OP      = 4'd2;
  localparam logic [3:0] S_PHYAD   = 4'd3;
  localparam logic [3:0] S_REGAD   = 4'd4;
  localparam logic [3:0] S_TA      = 4'd5;
  localparam logic [3:0] S_RD_DATA = 4'd6;
  localparam logic [3:0] S_WR_DATA = 4'd7;
  localparam logic [3:0] S_SKIP    = 4'd8;

  localparam int             PW      = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0]  PRE_MAX = PW'(PREAMBLE_MIN);

  logic          mdc_s1, mdc_s2, mdc_d;
  logic          mdio_s1, mdio_s2;
  logic          rise;
  logic          bit_in;
  logic [3:0]    state;
  logic [PW-1:0] pre_cnt;
  logic [4:0]    bit_cnt;
  logic          op_b0;
  logic          is_read;
  logic [4:0]    phy_sh;
  logic [3:0]    reg_sh;
  logic [15:0]   sh;
  logic          rd_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_d   <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s2 <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      mdio_s1 <= mdio_i;
      mdio_s2 <= mdio_s1;
    end
  end

  assign rise   = mdc_s2 & ~mdc_d;
  assign bit_in = mdio_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      op_b0     <= 1'b0;
      is_read   <= 1'b0;
      phy_sh    <= '0;
      reg_sh    <= '0;
      sh        <= '0;
      rd_cap    <= 1'b0;
      mdio_o    <= 1'b0;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
      // register file presents read data one clk after the strobe
      rd_cap    <= reg_re;
      if (rd_cap) sh <= reg_rdata;
      if (state != S_IDLE) pre_cnt <= '0;

      if (rise) begin
        case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
            end else begin
              pre_cnt <= '0;
              if (pre_cnt == PRE_MAX) state <= S_ST;
            end
          end

          S_ST: begin
            if (bit_in) begin
              state   <= S_OP;
              busy    <= 1'b1;
              bit_cnt <= 5'd1;
            end else begin
              frame_err <= 1'b1;
              state     <= S_IDLE;
            end
          end

          S_OP: begin
            op_b0 <= bit_in;
            if (bit_cnt == 5'd0) begin
              case ({op_b0, bit_in})
                2'b10: begin
                  is_read <= 1'b1;
                  state   <= S_PHYAD;
                  bit_cnt <= 5'd4;
                end
                2'b01: begin
                  is_read <= 1'b0;
                  state   <= S_PHYAD;
                  bit_cnt <= 5'd4;
                end
                default: begin
                  frame_err <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
                end
              endcase
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end

          S_PHYAD: begin
            phy_sh <= {phy_sh[3:0], bit_in};
            if (bit_cnt == 5'd0) begin
              state   <= S_REGAD;
              bit_cnt <= 5'd4;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end

          S_REGAD: begin
            reg_sh <= {reg_sh[2:0], bit_in};
            if (bit_cnt == 5'd0) begin
              if (phy_sh == PHY_ADDR) begin
                reg_addr <= {reg_sh, bit_in};
                reg_re   <= is_read;
                state    <= S_TA;
                bit_cnt  <= 5'd1;
              end else begin
                // TA plus 16 data bits belong to someone else
                state   <= S_SKIP;
                bit_cnt <= 5'd17;
              end
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end

          S_TA: begin
            if (is_read) begin
              if (bit_cnt == 5'd0) begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b0;
                state   <= S_RD_DATA;
                bit_cnt <= 5'd16;
              end else begin
                bit_cnt <= 5'd0;
              end
            end else if ((bit_cnt != 5'd0) ? !bit_in : bit_in) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else if (bit_cnt != 5'd0) begin
              bit_cnt <= 5'd0;
            end else begin
              state   <= S_WR_DATA;
              bit_cnt <= 5'd15;
            end
          end

          S_RD_DATA: begin
            if (bit_cnt == 5'd0) begin
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              mdio_o  <= sh[15];
              sh      <= {sh[14:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
            end
          end

          S_WR_DATA: begin
            sh <= {sh[14:0], bit_in};
            if (bit_cnt == 5'd0) begin
              reg_wdata <= {sh[14:0], bit_in};
              reg_we    <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end

          S_SKIP: begin
            if (bit_cnt == 5'd0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end

          default: begin
            mdio_oe <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: station model drives mdc at clk/8 and
// checks strobes, turnaround and read drive against hand-computed values.
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        busy;
  logic        frame_err;

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_MIN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .reg_addr  (reg_addr),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          re_cnt = 0;
  int          we_cnt = 0;
  int          ferr_cnt = 0;
  int          oe_cnt = 0;
  int          both_cnt = 0;
  logic [4:0]  re_addr = '0;
  logic [4:0]  we_ad [0:15];
  logic [15:0] we_wd [0:15];

  // strobe monitor sampling away from the active edge
  always @(negedge clk) begin
    if (reg_re) begin
      re_cnt  <= re_cnt + 1;
      re_addr <= reg_addr;
    end
    if (reg_we) begin
      we_cnt <= we_cnt + 1;
      if (we_cnt < 16) begin
        we_ad[we_cnt] <= reg_addr;
        we_wd[we_cnt] <= reg_wdata;
      end
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (mdio_oe) oe_cnt <= oe_cnt + 1;
    if (reg_re && reg_we) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_tx(input logic b);
    mdc    = 1'b0;
    mdio_i = b;
    repeat (4) @(negedge clk);
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic bits_tx(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_tx(v[i]);
  endtask

  task automatic preamble(input int n);
    repeat (n) bit_tx(1'b1);
  endtask

  task automatic hdr(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra);
    bits_tx(32'({2'b01, op, pa, ra}), 14);
  endtask

  task automatic read_body(output logic [1:0] ta_oe, output logic ta2_o,
                           output logic [15:0] d, output logic [15:0] d_oe,
                           output logic end_oe);
    bit_tx(1'b1);
    ta_oe[1] = mdio_oe;
    bit_tx(1'b1);
    ta_oe[0] = mdio_oe;
    ta2_o    = mdio_o;
    for (int i = 0; i < 16; i++) begin
      bit_tx(1'b1);
      d[15-i]    = mdio_o;
      d_oe[15-i] = mdio_oe;
    end
    bit_tx(1'b1);
    end_oe = mdio_oe;
  endtask

  logic [1:0]  ta_oe;
  logic        ta2_o;
  logic [15:0] rd_d, rd_oe;
  logic        end_oe;
  int          b_re, b_we, b_ferr, b_oe;

  initial begin
    rst       = 1'b1;
    mdc       = 1'b0;
    mdio_i    = 1'b1;
    reg_rdata = 16'hA5C3;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({mdio_o, mdio_oe, reg_re, reg_we, busy, frame_err, reg_addr, reg_wdata}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // addressed read of register 2
    b_re = re_cnt;
    preamble(32);
    hdr(2'b10, 5'd1, 5'd2);
    read_body(ta_oe, ta2_o, rd_d, rd_oe, end_oe);
    check("rd_re_pulses", 32'(re_cnt - b_re), 32'd1);
    check("rd_re_addr", 32'(re_addr), 32'd2);
    check("rd_ta1_oe", 32'(ta_oe[1]), 32'd0);
    check("rd_ta2_oe", 32'(ta_oe[0]), 32'd1);
    check("rd_ta2_o", 32'(ta2_o), 32'd0);
    check("rd_data", 32'(rd_d), 32'h0000A5C3);
    check("rd_data_oe", 32'(rd_oe), 32'h0000FFFF);
    check("rd_end_oe", 32'(end_oe), 32'd0);
    check("rd_end_busy", 32'(busy), 32'd0);

    // addressed write of register 4
    b_we = we_cnt; b_oe = oe_cnt;
    preamble(32);
    hdr(2'b01, 5'd1, 5'd4);
    bits_tx(32'b10, 2);
    bits_tx(32'h1234, 16);
    check("wr_we_pulses", 32'(we_cnt - b_we), 32'd1);
    check("wr_addr", 32'(we_ad[b_we]), 32'd4);
    check("wr_data", 32'(we_wd[b_we]), 32'h1234);
    check("wr_oe_quiet", 32'(oe_cnt - b_oe), 32'd0);

    // read frame for PHY 3 is skipped
    b_re = re_cnt; b_we = we_cnt; b_oe = oe_cnt; b_ferr = ferr_cnt;
    preamble(32);
    hdr(2'b10, 5'd3, 5'd2);
    preamble(17);
    check("skip_busy_17", 32'(busy), 32'd1);
    bit_tx(1'b1);
    check("skip_busy_18", 32'(busy), 32'd0);
    check("skip_no_re", 32'(re_cnt - b_re), 32'd0);
    check("skip_no_we", 32'(we_cnt - b_we), 32'd0);
    check("skip_oe_quiet", 32'(oe_cnt - b_oe), 32'd0);
    check("skip_no_ferr", 32'(ferr_cnt - b_ferr), 32'd0);
    preamble(32);
    hdr(2'b01, 5'd1, 5'd7);
    bits_tx(32'b10, 2);
    bits_tx(32'hBEEF, 16);
    check("after_skip_we", 32'(we_cnt - b_we), 32'd1);
    check("after_skip_data", 32'({we_ad[b_we], we_wd[b_we]}), 32'({5'd7, 16'hBEEF}));

    // 31-one preamble: frame ignored
    b_we = we_cnt; b_ferr = ferr_cnt;
    preamble(31);
    bits_tx(32'b01, 2);
    check("short_pre_busy", 32'(busy), 32'd0);
    bits_tx(32'({2'b01, 5'd1, 5'd4, 2'b10}), 14);
    bits_tx(32'h1234, 16);
    check("short_pre_no_we", 32'(we_cnt - b_we), 32'd0);
    check("short_pre_no_ferr", 32'(ferr_cnt - b_ferr), 32'd0);

    // illegal opcode 11
    b_ferr = ferr_cnt;
    preamble(32);
    bits_tx(32'b0111, 4);
    check("op11_ferr", 32'(ferr_cnt - b_ferr), 32'd1);
    check("op11_busy", 32'(busy), 32'd0);

    // write with bad turnaround 11
    b_ferr = ferr_cnt; b_we = we_cnt;
    preamble(32);
    hdr(2'b01, 5'd1, 5'd4);
    bits_tx(32'b11, 2);
    check("ta11_ferr", 32'(ferr_cnt - b_ferr), 32'd1);
    bits_tx(32'h1234, 16);
    check("ta11_no_we", 32'(we_cnt - b_we), 32'd0);

    // reset while bit 7 of read data is on the line
    preamble(32);
    hdr(2'b10, 5'd1, 5'd2);
    bits_tx(32'b11, 2);
    bits_tx(32'h1FF, 9);
    check("rstmid_oe_before", 32'(mdio_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_oe", 32'(mdio_oe), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    mdc = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    reg_rdata = 16'h5A3C;
    b_re = re_cnt;
    preamble(32);
    hdr(2'b10, 5'd1, 5'd9);
    read_body(ta_oe, ta2_o, rd_d, rd_oe, end_oe);
    check("rstmid_next_re", 32'({re_cnt - b_re, 27'd0, re_addr} & 32'hFFFF_FFFF), 32'({32'd1, 27'd0, 5'd9}));
    check("rstmid_next_data", 32'(rd_d), 32'h00005A3C);
    check("rstmid_next_ta", 32'({ta_oe, ta2_o}), 32'b010);
    check("rstmid_next_end_oe", 32'(end_oe), 32'd0);

    // back-to-back writes with minimum preamble
    b_we = we_cnt;
    preamble(32);
    hdr(2'b01, 5'd1, 5'd9);
    bits_tx(32'b10, 2);
    bits_tx(32'h0F0F, 16);
    preamble(32);
    hdr(2'b01, 5'd1, 5'd10);
    bits_tx(32'b10, 2);
    bits_tx(32'hC001, 16);
    check("b2b_we_pulses", 32'(we_cnt - b_we), 32'd2);
    check("b2b_first", 32'({we_ad[b_we], we_wd[b_we]}), 32'({5'd9, 16'h0F0F}));
    check("b2b_second", 32'({we_ad[b_we+1], we_wd[b_we+1]}), 32'({5'd10, 16'hC001}));

    check("re_we_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
